// File: rtl/soc_system_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO control block.
// Read data is always a full 32-bit word; the PIO zero-fills unused upper bits.
interface soc_system_pio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_ctrl.sv
// HPS-to-FPGA PIO: output register with atomic set/clear, timed update strobe,
// synchronised inputs with edge capture, and a maskable level interrupt.
module soc_system_pio_ctrl #(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_VALUE   = 32'h0,
  parameter int          EDGE_TYPE     = 0,
  parameter int          SYNC_STAGES   = 2,
  parameter int          STROBE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  soc_system_pio_ctrl_if.slave   bus,
  input  logic [DATA_WIDTH-1:0]  in_port,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   out_strobe,
  output logic                   irq
);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    A_DATA    = 3'd0,
    A_IN      = 3'd1,
    A_IRQMASK = 3'd2,
    A_EDGECAP = 3'd3,
    A_OUTSET  = 3'd4,
    A_OUTCLR  = 3'd5,
    A_STATUS  = 3'd6,
    A_RSVD    = 3'd7
  } addr_e;

  addr_e          addr;
  logic           wr;
  logic [DW-1:0]  wd;

  logic [DW-1:0]  data_q, data_nxt;
  logic           data_ld;
  logic [DW-1:0]  irqmask_q;
  logic [DW-1:0]  edgecap_q;
  logic [DW-1:0]  w1c;
  logic [7:0]     cnt_q;

  logic [SYNC_STAGES-1:0][DW-1:0] sync_q;
  logic [DW-1:0]  sync_in, prev_q, evt;
  logic [31:0]    rd;

  assign addr = addr_e'(bus.address);
  assign wr   = bus.chipselect & ~bus.write_n;
  assign wd   = bus.writedata[DW-1:0];

  // Any write to DATA/OUTSET/OUTCLR counts as an output update, even if the value is unchanged.
  always_comb begin
    data_nxt = data_q;
    data_ld  = 1'b0;
    if (wr) begin
      case (addr)
        A_DATA:   begin data_nxt = wd;             data_ld = 1'b1; end
        A_OUTSET: begin data_nxt = data_q | wd;    data_ld = 1'b1; end
        A_OUTCLR: begin data_nxt = data_q & ~wd;   data_ld = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= RESET_VALUE[DW-1:0];
      irqmask_q <= '0;
      cnt_q     <= '0;
    end else begin
      data_q <= data_nxt;
      if (wr && addr == A_IRQMASK) irqmask_q <= wd;
      if (data_ld)          cnt_q <= 8'(STROBE_CYCLES);
      else if (cnt_q != 0)  cnt_q <= cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign evt = sync_in & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign evt = ~sync_in & prev_q;
    end else begin : g_any
      assign evt = sync_in ^ prev_q;
    end
  endgenerate

  // Clear is applied before the OR so a same-cycle edge wins over W1C.
  assign w1c = (wr && addr == A_EDGECAP) ? wd : '0;

  always_ff @(posedge clk) begin
    if (reset) edgecap_q <= '0;
    else       edgecap_q <= (edgecap_q & ~w1c) | evt;
  end

  always_comb begin
    rd = '0;
    case (addr)
      A_DATA:    rd[DW-1:0] = data_q;
      A_IN:      rd[DW-1:0] = sync_in;
      A_IRQMASK: rd[DW-1:0] = irqmask_q;
      A_EDGECAP: rd[DW-1:0] = edgecap_q;
      A_STATUS:  begin rd[0] = out_strobe; rd[15:8] = cnt_q; end
      default:   ;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = data_q;
  assign out_strobe   = (cnt_q != 8'd0);
  assign irq          = |(edgecap_q & irqmask_q);
endmodule

// File: doc/soc_system_pio_ctrl.md
Name: soc_system_pio_ctrl

Overview:
- Parametrised Avalon-MM slave PIO for HPS-to-FPGA control of the filter pipeline. Next generation of the plain 32-bit output PIO.
- Adds:
  - atomic bit-set and bit-clear writes;
  - a timed update strobe on every output change;
  - a synchronised input port with edge capture;
  - a maskable interrupt.
- Sits between the HPS lightweight bridge and the image-processing control/status signals.

Parameters:
- DATA_WIDTH, 32: width of out_port, in_port and all registers (1..32). readdata bits above DATA_WIDTH read 0.
- RESET_VALUE, 0: value loaded into the output register on reset.
- EDGE_TYPE, 0: input edge to capture. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser flops on in_port (2..4).
- STROBE_CYCLES, 1: length in clocks of the out_strobe pulse (1..255).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- address  input  3  word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write
- writedata  input  32  write data
- readdata  output  32  read data, zero wait states, combinational from registers
- in_port  input  DATA_WIDTH  asynchronous status inputs from fabric
- out_port  output  DATA_WIDTH  control outputs, driven directly from the output register
- out_strobe  output  1  high for STROBE_CYCLES after any output-register write
- irq  output  1  level interrupt request

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Write = chipselect && !write_n, sampled at the rising clk edge. Reads have no side effects.
- Register map (word address):
  - 0 DATA: R/W. Write loads writedata[DATA_WIDTH-1:0].
  - 1 IN: read-only, synchronised in_port.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: read. Write-1-to-clear per bit.
  - 4 OUTSET: write-only, data <= data | wd. Reads 0.
  - 5 OUTCLR: write-only, data <= data & ~wd. Reads 0.
  - 6 STATUS: read-only. bit0 = out_strobe; bits[15:8] = strobe counter value; others 0.
  - 7: reserved. Reads 0, writes ignored.
- Reset values:
  - data = RESET_VALUE; irqmask = 0; edgecap = 0.
  - Synchroniser flops and the previous-sample register = 0.
  - Strobe counter = 0, so out_strobe = 0 and irq = 0.
- Output latency: out_port takes the new value on the clock edge that samples the write, i.e. it is visible the cycle after the write cycle.
- Strobe counter (8-bit):
  - A write to address 0, 4 or 5 loads STROBE_CYCLES. This happens even if the data value is unchanged.
  - Otherwise the counter decrements while nonzero.
  - out_strobe = (counter != 0). It rises in the same cycle out_port updates and lasts exactly STROBE_CYCLES cycles.
  - A write while the strobe is active reloads the counter (retrigger; no gap, pulse extended).
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in; a further flop gives prev.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - The selected event sets the matching edgecap bit.
  - Same-cycle W1C and new edge on the same bit: set wins.
  - Bits not written with 1 hold their value.
- irq = |(edgecap & irqmask). It is combinational from registers and asserts the cycle after the edge is captured, or the cycle after the mask write.
- IN read latency from an in_port change: SYNC_STAGES cycles.
- Reset mid-operation: reset overrides any same-cycle write and aborts an active strobe. out_strobe is low the cycle after reset.
- Writes narrower than 32 bits are not supported; byte enables are absent. Upper writedata bits beyond DATA_WIDTH are ignored.

Test Plan:
- Reset with RESET_VALUE=32'h0000_00A5 -> out_port=0xA5; out_strobe=0; irq=0; readdata at addresses 2, 3 and 6 = 0.
- Write 0x12345678 to addr 0 with STROBE_CYCLES=3 -> out_port=0x12345678 the next cycle; out_strobe high exactly 3 cycles; addr 0 reads 0x12345678.
- From data=0x0000_00F0: OUTSET 0x0F, then OUTCLR 0x30 -> out_port 0xFF, then 0xCF. Reads of addr 4/5 return 0. Two strobe pulses, the second retriggering the first.
- EDGE_TYPE=0, IRQMASK=0x1, in_port[0] 0->1 -> EDGECAP reads 0x1 after SYNC_STAGES+1 cycles; irq=1. Write 0x1 to addr 3 -> EDGECAP=0, irq=0. A 1->0 transition captures nothing.
- EDGE_TYPE=2: toggle in_port[3] on the same cycle as the W1C of bit 3 reaches the capture register -> bit 3 remains 1 (set wins).
- Assert reset during an active strobe with a write in the same cycle -> out_port=RESET_VALUE; out_strobe=0 next cycle; the write is discarded.
